// File: rtl/fp_pack_register_if.sv
// Handshake bundle between the SRT divider datapath and the IEEE-754 pack/output register.
// The producer side drives the unpacked result and consumes the packed word.
interface fp_pack_register_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   logic                     in_valid;
   logic                     in_ready;
   logic                     in_sign;
   logic signed [EXP_W+1:0]  in_exp;
   logic [MAN_W+2:0]         in_man;
   logic                     in_nan;
   logic                     in_inf;
   logic                     in_zero;
   logic                     out_valid;
   logic                     out_ready;
   logic [EXP_W+MAN_W:0]     out_float;
   logic [3:0]               out_flags;

   modport master (
      output in_valid, in_sign, in_exp, in_man, in_nan, in_inf, in_zero, out_ready,
      input  in_ready, out_valid, out_float, out_flags
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_man, in_nan, in_inf, in_zero, out_ready,
      output in_ready, out_valid, out_float, out_flags
   );
endinterface

// File: rtl/fp_pack_register.sv
// Round-to-nearest-even packer and one-deep output register for the SRT divider result,
// with overflow/underflow/special-case handling and sticky exception flags.
module fp_pack_register_chk #(
   parameter int FW = 32
) (
   input logic          clk,
   input logic          resetn,
   input logic          in_ready,
   input logic          out_valid,
   input logic          out_ready,
   input logic [FW-1:0] out_float,
   input logic [3:0]    out_flags
);
   // A stalled word must stay put until the consumer takes it
   a_hold_stable: assert property (@(posedge clk) disable iff (!resetn)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_float) && $stable(out_flags)));

   a_ready_rule: assert property (@(posedge clk) disable iff (!resetn)
      in_ready == (!out_valid || out_ready));
endmodule

module fp_pack_register #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic               clk,
   input  logic               resetn,
   fp_pack_register_if.slave  bus,
   input  logic               clr_flags,
   output logic [3:0]         sticky_flags
);
   localparam int FW = 1 + EXP_W + MAN_W;
   // One bit of headroom over in_exp so the rounding carry can never wrap the sign
   localparam int XW = EXP_W + 3;
   localparam logic signed [XW-1:0] EXP_MAX = {3'b000, {EXP_W{1'b1}}};

   logic [MAN_W-1:0]      fraction_s;
   logic                  lsb_s;
   logic                  g_s;
   logic                  r_s;
   logic                  s_s;
   logic                  inc_s;
   logic                  inexact_s;
   logic                  carry_s;
   logic [MAN_W:0]        frac_r_s;
   logic signed [XW-1:0]  exp_r_s;
   logic                  ovf_s;
   logic                  unf_s;
   logic [FW-1:0]         packed_s;
   logic [3:0]            flags_s;
   logic                  accept_s;

   logic                  out_valid_r;
   logic [FW-1:0]         out_float_r;
   logic [3:0]            out_flags_r;
   logic [3:0]            sticky_r;

   // Nearest-even rounding of the fraction and exponent adjust on mantissa carry-out
   always_comb begin
      fraction_s = bus.in_man[MAN_W+2:3];
      lsb_s      = bus.in_man[3];
      g_s        = bus.in_man[2];
      r_s        = bus.in_man[1];
      s_s        = bus.in_man[0];
      inc_s      = g_s & (lsb_s | r_s | s_s);
      inexact_s  = g_s | r_s | s_s;
      frac_r_s   = {1'b0, fraction_s} + {{MAN_W{1'b0}}, inc_s};
      carry_s    = frac_r_s[MAN_W];
      exp_r_s    = {bus.in_exp[EXP_W+1], bus.in_exp} + {{(XW-1){1'b0}}, carry_s};
      ovf_s      = (exp_r_s >= EXP_MAX);
      unf_s      = exp_r_s[XW-1] | (exp_r_s == {XW{1'b0}});
   end

   // Result classification; flags are {invalid, overflow, underflow, inexact}
   always_comb begin
      packed_s = {FW{1'b0}};
      flags_s  = 4'b0000;
      if (bus.in_nan) begin
         packed_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         flags_s  = 4'b1000;
      end else if (bus.in_inf) begin
         packed_s = {bus.in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_s  = 4'b0000;
      end else if (bus.in_zero) begin
         packed_s = {bus.in_sign, {(EXP_W+MAN_W){1'b0}}};
         flags_s  = 4'b0000;
      end else if (ovf_s) begin
         packed_s = {bus.in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_s  = 4'b0101;
      end else if (unf_s) begin
         packed_s = {bus.in_sign, {(EXP_W+MAN_W){1'b0}}};
         flags_s  = 4'b0011;
      end else begin
         packed_s = {bus.in_sign, exp_r_s[EXP_W-1:0], frac_r_s[MAN_W-1:0]};
         flags_s  = {3'b000, inexact_s};
      end
   end

   assign bus.in_ready = !out_valid_r | bus.out_ready;
   assign accept_s     = bus.in_valid & bus.in_ready;

   // Output word register: load on accept, retire on transfer, hold under backpressure
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_r <= 1'b0;
         out_float_r <= {FW{1'b0}};
         out_flags_r <= 4'b0000;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_float_r <= packed_s;
         out_flags_r <= flags_s;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // Sticky accumulation; an accept on the clearing edge keeps only the new word's flags
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sticky_r <= 4'b0000;
      end else if (accept_s) begin
         sticky_r <= (clr_flags ? 4'b0000 : sticky_r) | flags_s;
      end else if (clr_flags) begin
         sticky_r <= 4'b0000;
      end else begin
         sticky_r <= sticky_r;
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_float = out_float_r;
   assign bus.out_flags = out_flags_r;
   assign sticky_flags  = sticky_r;

   fp_pack_register_chk #(.FW(FW)) u_chk (
      .clk       (clk),
      .resetn    (resetn),
      .in_ready  (bus.in_ready),
      .out_valid (out_valid_r),
      .out_ready (bus.out_ready),
      .out_float (out_float_r),
      .out_flags (out_flags_r)
   );
endmodule

// File: doc/fp_pack_register.md
Name: fp_pack_register

Overview:
- Parametrised, handshaked successor to the fixed 32-bit IEEE-754 output register.
- Takes the unpacked result from the radix-4 SRT divider datapath: sign, wide signed biased exponent, normalised fraction with guard/round/sticky bits, and special-case flags.
- Rounds to nearest-even and handles overflow, underflow and NaN/Inf/zero.
- Registers the packed word behind a valid/ready interface and keeps sticky exception flags.

Parameters:
EXP_W, 8, exponent field width (8 single, 11 double)
MAN_W, 23, stored fraction width (23 single, 52 double)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  reset, asynchronous, active-low
in_valid  input  1  input word valid
in_ready  output  1  stage can accept input
in_sign  input  1  result sign
in_exp  input  EXP_W+2  signed two's-complement biased exponent (pre-rounding)
in_man  input  MAN_W+3  {fraction[MAN_W-1:0], G, R, S}; hidden 1 implied
in_nan  input  1  result is NaN (invalid operation)
in_inf  input  1  result is infinity (e.g. divide by zero)
in_zero  input  1  result is exact zero
out_valid  output  1  packed word valid
out_ready  input  1  downstream accepts word
out_float  output  1+EXP_W+MAN_W  {sign, exp, fraction}
out_flags  output  4  per-result {invalid, overflow, underflow, inexact}
clr_flags  input  1  synchronous clear of sticky_flags
sticky_flags  output  4  OR-accumulation of out_flags of accepted inputs

Behaviour:
- Reset (async, resetn=0): out_valid=0, out_float=0, out_flags=0, sticky_flags=0. in_ready=1 after reset. Reset mid-transfer discards the held word.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Input is accepted on a clock edge where in_valid & in_ready; out_* load the packed result on that same edge, so latency is 1 cycle.
  - An output transfer occurs on out_valid & out_ready. If no new input is accepted on that edge, out_valid drops to 0.
  - While out_valid & !out_ready: out_float and out_flags hold stable and no input is accepted.
  - Back-to-back full throughput when out_ready=1.
- Rounding (RNE), with lsb = in_man[3], G = in_man[2], R = in_man[1], S = in_man[0]:
  - inc = G & (lsb | R | S); inexact = G | R | S.
  - frac_r = fraction + inc, computed MAN_W+1 bits wide.
  - On carry out: frac = 0 and exp_r = in_exp + 1; otherwise exp_r = in_exp.
- Classification, priority nan > inf > zero > overflow > underflow > normal:
  - nan: canonical quiet NaN {0, all-ones, 1, zeros}; invalid=1, all other flags 0. Ignores in_sign.
  - inf: {in_sign, all-ones, zeros}; no flags.
  - zero: {in_sign, zeros}; no flags.
  - overflow (exp_r >= 2^EXP_W - 1, signed compare): {in_sign, all-ones, zeros}; overflow=1, inexact=1.
  - underflow (exp_r <= 0, signed compare): flush to {in_sign, zeros}; underflow=1, inexact=1. No subnormals are produced.
  - normal: {in_sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]}; inexact from rounding.
- Sticky flags:
  - On each accepted input, sticky_flags |= that word's flags.
  - clr_flags zeroes sticky_flags at the next edge.
  - If clr_flags and an accept occur on the same edge, the result is the new word's flags only: set wins over the prior value.
- Sizing: all widths derive from EXP_W/MAN_W; no hard-coded 32-bit constants.

Test Plan:
- Defaults, out_ready=1: in_exp=127, in_man=0 -> next cycle out_float=0x3F800000, out_flags=0.
- Tie cases:
  - fraction=0x000000, GRS=100 -> 0x3F800000, inexact=1.
  - fraction=0x000001, GRS=100 -> 0x3F800002, inexact=1.
- Rounding carry: in_exp=127, fraction=0x7FFFFF, GRS=110 -> 0x40000000.
- Exponent limits:
  - in_exp=255, sign=0 -> 0x7F800000, flags=0101.
  - in_exp=0, sign=1 -> 0x80000000, flags=0011.
  - in_nan=1 together with in_inf=1 -> 0x7FC00000, flags=1000.
- Backpressure:
  - Accept word A, then hold out_ready=0 for 3 cycles: out_float=A stable, in_ready=0.
  - Release: A transfers and word B is accepted on the same edge.
- Flags and reset:
  - Overflow then underflow results -> sticky=0111.
  - clr_flags on the same edge as a NaN accept -> sticky=1000.
  - resetn=0 asserted asynchronously while out_valid=1 -> out_valid=0 and sticky=0 immediately.
- Double precision (EXP_W=11, MAN_W=52): in_exp=1023, in_man=0 -> 0x3FF0000000000000.
